// File: rtl/y86_pkg.sv
// Shared constants for the pipelined Y86 register file.
// Register index codes, the RNONE code and default widths.
package y86_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 4;

    localparam logic [3:0] RNONE = 4'hF;

    localparam int RAX = 0;
    localparam int RCX = 1;
    localparam int RDX = 2;
    localparam int RBX = 3;
    localparam int RSP = 4;
    localparam int RBP = 5;
    localparam int RSI = 6;
    localparam int RDI = 7;
    localparam int R8  = 8;
    localparam int R9  = 9;
    localparam int R10 = 10;
    localparam int R11 = 11;
    localparam int R12 = 12;
    localparam int R13 = 13;
    localparam int R14 = 14;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: per-register in-flight counters,
// saturating/clamping update, flush and sticky error flag.
module regfile_scoreboard
    import y86_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = 15,
    parameter int CNT_W    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] dst_e,
    input  logic [ADDR_W-1:0] dst_m,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_dst_e,
    input  logic [ADDR_W-1:0] rsv_dst_m,
    input  logic              flush,
    input  logic [ADDR_W-1:0] qa,
    input  logic [ADDR_W-1:0] qb,
    output logic              busy_a,
    output logic              busy_b,
    output logic              err
);

    localparam int NW = CNT_W + 3;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic             err_q;
    logic             err_d;

    logic [ADDR_W-1:0] none;
    assign none = ADDR_W'(RNONE);

    always_comb begin
        logic [1:0]          inc;
        logic [1:0]          dec;
        logic signed [NW-1:0] net;
        logic                busy;
        err_d  = err_q;
        busy_a = 1'b0;
        busy_b = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc = {1'b0, rsv_en && rsv_dst_e == ADDR_W'(i) && rsv_dst_e != none}
                + {1'b0, rsv_en && rsv_dst_m == ADDR_W'(i) && rsv_dst_m != none};
            dec = {1'b0, wb_valid && dst_e == ADDR_W'(i) && dst_e != none}
                + {1'b0, wb_valid && dst_m == ADDR_W'(i) && dst_m != none};
            net = $signed({3'b000, cnt_q[i]})
                + $signed({{(NW-2){1'b0}}, inc})
                - $signed({{(NW-2){1'b0}}, dec});
            cnt_d[i] = net[CNT_W-1:0];
            if (flush) begin
                cnt_d[i] = '0;
            end else if (net > $signed({3'b000, CMAX})) begin
                cnt_d[i] = CMAX;
                err_d    = 1'b1;
            end else if (net < 0) begin
                cnt_d[i] = '0;
                err_d    = 1'b1;
            end
`ifdef REGFILE_BYPASS_EN
            // a register whose last pending writes retire now is not busy
            busy = {2'b00, cnt_q[i]} > {{CNT_W{1'b0}}, dec};
`else
            busy = cnt_q[i] != '0;
`endif
            if (qa == ADDR_W'(i) && qa != none) busy_a = busy;
            if (qb == ADDR_W'(i) && qb != none) busy_b = busy;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/y86_regfile_sb.sv
// Y86 register file with two read, two write ports and a pending-write
// scoreboard. Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module y86_regfile_sb
    import y86_pkg::*;
#(
    parameter int                NUM_REGS = 15,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                CNT_W    = 2,
    parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic              we_e,
    input  logic [ADDR_W-1:0] dstM,
    input  logic [DATA_W-1:0] valM,
    input  logic              we_m,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_dstE,
    input  logic [ADDR_W-1:0] rsv_dstM,
    input  logic              flush,
    output logic              err
);

    logic [DATA_W-1:0] reg_q [NUM_REGS];
    logic [DATA_W-1:0] reg_d [NUM_REGS];
    logic              wr_e;
    logic              wr_m;

    assign wr_e = wb_valid && we_e && dstE != ADDR_W'(RNONE);
    assign wr_m = wb_valid && we_m && dstM != ADDR_W'(RNONE);

    // M is applied last so it wins when both target one register
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_d[i] = reg_q[i];
            if (wr_e && dstE == ADDR_W'(i)) reg_d[i] = valE;
            if (wr_m && dstM == ADDR_W'(i)) reg_d[i] = valM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                reg_q[i] <= (i == RSP) ? RSP_INIT : '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= reg_d[i];
        end
    end

    always_comb begin
        valA = '0;
        valB = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
`ifdef REGFILE_BYPASS_EN
            if (srcA == ADDR_W'(i)) valA = reg_d[i];
            if (srcB == ADDR_W'(i)) valB = reg_d[i];
`else
            if (srcA == ADDR_W'(i)) valA = reg_q[i];
            if (srcB == ADDR_W'(i)) valB = reg_q[i];
`endif
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_valid  (wb_valid),
        .dst_e     (dstE),
        .dst_m     (dstM),
        .rsv_en    (rsv_en),
        .rsv_dst_e (rsv_dstE),
        .rsv_dst_m (rsv_dstM),
        .flush     (flush),
        .qa        (srcA),
        .qb        (srcB),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .err       (err)
    );

endmodule

// File: tb/tb_y86_regfile_sb.sv
// Directed bench for y86_regfile_sb with an expectation queue.
// Expected values are queued with the stimulus and popped at check time.
module tb_y86_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  srcA, srcB, dstE, dstM, rsv_dstE, rsv_dstM;
    logic [63:0] valA, valB, valE, valM;
    logic        busy_a, busy_b, err;
    logic        wb_valid, we_e, we_m, rsv_en, flush;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    y86_regfile_sb #(.RSP_INIT(64'h1000)) dut (
        .clk(clk), .rst_n(rst_n),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .busy_a(busy_a), .busy_b(busy_b),
        .wb_valid(wb_valid),
        .dstE(dstE), .valE(valE), .we_e(we_e),
        .dstM(dstM), .valM(valM), .we_m(we_m),
        .rsv_en(rsv_en), .rsv_dstE(rsv_dstE), .rsv_dstM(rsv_dstM),
        .flush(flush), .err(err)
    );

    task automatic exp(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic chk(input logic [63:0] obs);
        exp_t e;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $error("FAIL sb_empty: got %h want queued value", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s: got %h want %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic idle();
        wb_valid = 0; we_e = 0; we_m = 0; rsv_en = 0; flush = 0;
        dstE = 4'hF; dstM = 4'hF; rsv_dstE = 4'hF; rsv_dstM = 4'hF;
        valE = '0; valM = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #2;
    endtask

    task automatic rsv(input logic [3:0] e, input logic [3:0] m);
        rsv_en = 1; rsv_dstE = e; rsv_dstM = m;
    endtask

    task automatic wb(input logic [3:0] de, input logic [63:0] ve, input logic ee,
                      input logic [3:0] dm, input logic [63:0] vm, input logic em);
        wb_valid = 1;
        dstE = de; valE = ve; we_e = ee;
        dstM = dm; valM = vm; we_m = em;
    endtask

    initial begin
        idle();
        srcA = 4'd4; srcB = 4'd5;
        rst_n = 0;
        #12;
        exp("rst_rsp", 64'h1000); exp("rst_r5", 0);
        exp("rst_busy_a", 0); exp("rst_busy_b", 0); exp("rst_err", 0);
        chk(valA); chk(valB); chk(64'(busy_a)); chk(64'(busy_b)); chk(64'(err));
        @(negedge clk); rst_n = 1;

        srcA = 4'hF; srcB = 4'd14;
        #1;
        exp("rnone_val", 0); exp("rnone_busy", 0); exp("r14_val", 0);
        chk(valA); chk(64'(busy_a)); chk(valB);

        // reserve 8 and 10, then retire both writes
        @(negedge clk);
        rsv(4'd8, 4'd10);
        exp("rsv8_busy", 1); exp("rsv10_busy", 1);
        tick();
        srcA = 4'd8; srcB = 4'd10; #1;
        chk(64'(busy_a)); chk(64'(busy_b));
        wb(4'd8, 64'h012a, 1, 4'd10, 64'h0546b, 1);
        exp("wr8", 64'h012a); exp("wr10", 64'h0546b);
        exp("rel8_busy", 0); exp("rel10_busy", 0); exp("err_ok", 0);
        tick();
        chk(valA); chk(valB); chk(64'(busy_a)); chk(64'(busy_b)); chk(64'(err));

        // double reserve / double release of %rsp, M wins
        srcA = 4'd4;
        rsv(4'd4, 4'd4);
        exp("rsv4x2_busy", 1);
        tick(); chk(64'(busy_a));
        wb(4'd4, 64'h10, 1, 4'd4, 64'h20, 1);
        exp("rsp_m_wins", 64'h20); exp("rel4x2_busy", 0); exp("err_ok2", 0);
        tick(); chk(valA); chk(64'(busy_a)); chk(64'(err));

        // not-taken cmov still releases, data unchanged
        srcA = 4'd6;
        rsv(4'd6, 4'hF);
        tick();
        wb(4'd6, 64'hdead, 0, 4'hF, 0, 0);
        exp("cmov_nowr", 0); exp("cmov_rel", 0); exp("err_ok3", 0);
        tick(); chk(valA); chk(64'(busy_a)); chk(64'(err));

        // saturation on register 3
        srcA = 4'd3;
        for (int k = 0; k < 3; k++) begin
            rsv(4'd3, 4'hF);
            exp($sformatf("sat_busy%0d", k), 1); exp($sformatf("sat_err%0d", k), 0);
            tick(); chk(64'(busy_a)); chk(64'(err));
        end
        rsv(4'd3, 4'hF);
        exp("sat_err", 1);
        tick(); chk(64'(err));
        for (int k = 0; k < 3; k++) begin
            wb(4'd3, 0, 0, 4'hF, 0, 0);
            exp($sformatf("drain%0d", k), (k < 2) ? 1 : 0);
            tick(); chk(64'(busy_a));
        end

        // simultaneous reserve/release, then flush
        srcA = 4'd5;
        rsv(4'd5, 4'hF);
        tick();
        rsv(4'd5, 4'hF);
        wb(4'd5, 0, 0, 4'hF, 0, 0);
        exp("rsvrel_busy", 1);
        tick(); chk(64'(busy_a));
        srcB = 4'd7;
        flush = 1;
        rsv(4'd5, 4'hF);
        wb(4'd7, 64'h77, 1, 4'hF, 0, 0);
        exp("flush_busy", 0); exp("flush_wr", 64'h77); exp("err_sticky", 1);
        tick(); chk(64'(busy_a)); chk(valB); chk(64'(err));

        // same-cycle write to register 2 seen before the edge
        srcA = 4'd2;
        wb(4'hF, 0, 0, 4'd2, 64'hABCD, 1);
        #1;
`ifdef REGFILE_BYPASS_EN
        exp("bypass_pre", 64'hABCD);
`else
        exp("bypass_pre", 0);
`endif
        chk(valA);
        exp("bypass_post", 64'hABCD);
        tick(); chk(valA);

        // async reset mid-operation
        srcA = 4'd9; srcB = 4'd4;
        rsv(4'd9, 4'hF);
        tick();
        exp("pre_rst_busy", 1);
        chk(64'(busy_a));
        #1 rst_n = 0; #1;
        exp("mid_rst_busy", 0); exp("mid_rst_err", 0); exp("mid_rst_rsp", 64'h1000);
        chk(64'(busy_a)); chk(64'(err)); chk(valB);
        srcA = 4'd8; #1;
        exp("mid_rst_r8", 0);
        chk(valA);
        @(negedge clk); rst_n = 1;

        if (sbq.size() != 0) begin
            bad++;
            $error("FAIL sb_leftover: got %0d want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running want done");
        $fatal(1, "timeout");
    end

endmodule
